// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;
    localparam int CSUM_BYTES     = 4;

    // States in which the loader consumes bytes from the stream
    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Byte-to-word shift register shared by the data and checksum phases.
// Bytes enter at the top so the first byte of a group ends up in [7:0].
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          shift_en,
    input  logic [7:0]                    byte_in,
    output logic [BYTES_PER_WORD*8-1:0]   word_next,
    output logic                          word_full
);

    localparam int WORD_W = BYTES_PER_WORD * 8;

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        idx_q, idx_d;

    // Shift in the current byte and track how many bytes of the word are present
    always_comb begin
        word_d    = word_q;
        idx_d     = idx_q;
        word_next = {byte_in, word_q[WORD_W-1:8]};
        word_full = shift_en && (idx_q == 2'(BYTES_PER_WORD - 1));
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shift_en) begin
            word_d = word_next;
            idx_d  = idx_q + 2'd1;
        end
    end

    // Word and index registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed, checksummed byte
// stream and writes it word-by-word into instruction memory while holding
// the processor in reset.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int WORD_W = BYTES_PER_WORD * 8;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CMP_W  = 17;   // wide enough for any 16-bit length and the word count

    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic [WORD_W-1:0]     acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wren_q, wren_d;
    logic                  ready_q, ready_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [TO_W-1:0]       idle_q, idle_d;

    logic                  xfer;
    logic                  start_ok;
    logic                  asm_shift;
    logic [15:0]           len_full;
    logic [WORD_W-1:0]     word_next;
    logic                  word_full;

    assign xfer      = byte_valid && ready_q;
    assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                 (state_q == ST_ERROR));
    assign asm_shift = xfer && ((state_q == ST_DATA) || (state_q == ST_CSUM));
    assign len_full  = {byte_in, len_lo_q};

    loader_word_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .clear     (start_ok),
        .shift_en  (asm_shift),
        .byte_in   (byte_in),
        .word_next (word_next),
        .word_full (word_full)
    );

    // Next-state, datapath updates and registered output values
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        words_d  = words_q;
        acc_d    = acc_q;
        addr_d   = addr_q;
        data_d   = data_q;
        idle_d   = idle_q;
        wren_d   = 1'b0;

        if (start_ok) begin
            state_d = ST_LEN0;
            words_d = '0;
            acc_d   = '0;
            idle_d  = '0;
        end else begin
            // Stall detector only runs while the stream is expected to flow
            if (accepts_bytes(state_q)) begin
                if (xfer) idle_d = '0;
                else      idle_d = idle_q + TO_W'(1);
            end

            case (state_q)
                ST_LEN0: begin
                    if (xfer) begin
                        len_lo_d = byte_in;
                        state_d  = ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (xfer) begin
                        len_d = len_full;
                        if (CMP_W'(len_full) > CMP_W'(DEPTH)) state_d = ST_ERROR;
                        else if (len_full == 16'd0)           state_d = ST_CSUM;
                        else                                   state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Capture the completed word so the write cycle drives registered values
                    if (word_full) begin
                        state_d = ST_WRITE;
                        addr_d  = words_q[ADDR_WIDTH-1:0];
                        data_d  = DATA_WIDTH'(word_next);
                        wren_d  = 1'b1;
                    end
                end
                ST_WRITE: begin
                    acc_d   = acc_q + WORD_W'(data_q);
                    words_d = words_q + 1'b1;
                    if (CMP_W'(words_q) + CMP_W'(1) < CMP_W'(len_q)) state_d = ST_DATA;
                    else                                             state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    if (word_full) begin
                        if (word_next == acc_q) state_d = ST_DONE;
                        else                    state_d = ST_ERROR;
                    end
                end
                default: ;
            endcase

            if (accepts_bytes(state_q) && !xfer && (idle_d == TO_W'(TIMEOUT_CYCLES)))
                state_d = ST_ERROR;
        end

        // Status outputs follow the state being entered, so they are flop outputs
        ready_d = accepts_bytes(state_d);
        hold_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d  = (state_d == ST_DONE);
        err_d   = (state_d == ST_ERROR);
    end

    // State and datapath registers; reset returns everything to idle and releases the CPU
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            words_q  <= '0;
            acc_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wren_q   <= 1'b0;
            ready_q  <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            words_q  <= words_d;
            acc_q    <= acc_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wren_q   <= wren_d;
            ready_q  <= ready_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
            idle_q   <= idle_d;
        end
    end

    assign byte_ready   = ready_q;
    assign imem_wren    = wren_q;
    assign imem_addr    = addr_q;
    assign imem_data    = data_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = err_q;
    assign words_loaded = words_q;

endmodule
